// File: rtl/vector_deserializer_if.sv
`default_nettype none
// ============================================================================
// Module      : vector_deserializer_if
// Description : Bundles the serial-bit handshake and the parallel-word
//               handshake of the vector deserializer.
//               master : drives bit_in/bit_valid/frame_start, vec_ready and
//                        clear_err; observes everything else.
//               slave  : the deserializer itself.
// Signals     : bit_in, bit_valid, frame_start, bit_ready  - serial side
//               vec[WIDTH], vec_valid, vec_ready            - word side
//               bit_count[$clog2(WIDTH+1)]                 - fill level
//               frame_err, clear_err                        - abort flag
// Revision    : 1.0  initial release
// ============================================================================
interface vector_deserializer_if #(
  parameter int WIDTH = 3
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             bit_in;
  logic             bit_valid;
  logic             frame_start;
  logic             bit_ready;
  logic [WIDTH-1:0] vec;
  logic             vec_valid;
  logic             vec_ready;
  logic [CW-1:0]    bit_count;
  logic             frame_err;
  logic             clear_err;

  modport master (
    output bit_in, bit_valid, frame_start, vec_ready, clear_err,
    input  bit_ready, vec, vec_valid, bit_count, frame_err
  );

  modport slave (
    input  bit_in, bit_valid, frame_start, vec_ready, clear_err,
    output bit_ready, vec, vec_valid, bit_count, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/vector_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : vector_deserializer
// Description : Collects framed serial bits into a WIDTH-bit word and offers
//               it downstream with a valid/ready handshake. A frame_start
//               arriving mid-word abandons the partial word and raises a
//               sticky frame_err.
// Ports       : clk   - system clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - vector_deserializer_if.slave (serial in, word out,
//                       bit_count, frame_err/clear_err)
// Parameters  : WIDTH     - word width, WIDTH >= 2
//               MSB_FIRST - 1: first serial bit lands in vec[WIDTH-1]
//                           0: first serial bit lands in vec[0]
// Revision    : 1.0  initial release
// ============================================================================
module vector_deserializer #(
  parameter int WIDTH     = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire                     clk,
  input  wire                     rst_n,
  vector_deserializer_if.slave    bus
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [WIDTH-1:0] vec_reg, vec_next;
  logic             vec_valid_reg, vec_valid_next;
  logic [CW-1:0]    count, count_next;
  logic             err_reg, err_next;
  logic             err_set;

  logic             ready;
  logic             accept;
  logic [WIDTH-1:0] shift_word;  // shift_reg with bit_in appended
  logic [WIDTH-1:0] load_word;   // bit_in as the first bit of a fresh word

  // In FULL a bit can only enter when the held word leaves the same cycle.
  assign ready  = (state == FULL) ? bus.vec_ready : 1'b1;
  assign accept = bus.bit_valid & ready;

  // Loading a first bit is the same as shifting it into an all-zero register.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shift_word = {shift_reg[WIDTH-2:0], bus.bit_in};
      assign load_word  = {{(WIDTH-1){1'b0}}, bus.bit_in};
    end else begin : g_lsb_first
      assign shift_word = {bus.bit_in, shift_reg[WIDTH-1:1]};
      assign load_word  = {bus.bit_in, {(WIDTH-1){1'b0}}};
    end
  endgenerate

  always_comb begin
    state_next     = state;
    shift_next     = shift_reg;
    vec_next       = vec_reg;
    vec_valid_next = vec_valid_reg;
    count_next     = count;
    err_set        = 1'b0;

    case (state)
      IDLE: begin
        // Bits without frame_start are stray and silently dropped here.
        if (accept && bus.frame_start) begin
          shift_next = load_word;
          count_next = CW'(1);
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        if (accept) begin
          if (bus.frame_start) begin
            err_set    = 1'b1;
            shift_next = load_word;
            count_next = CW'(1);
          end else begin
            shift_next = shift_word;
            if (count == LAST_CNT) begin
              vec_next       = shift_word;
              vec_valid_next = 1'b1;
              count_next     = '0;
              state_next     = FULL;
            end else begin
              count_next = count + CW'(1);
            end
          end
        end
      end

      FULL: begin
        if (bus.vec_ready) begin
          vec_valid_next = 1'b0;
          // A frame_start coinciding with consumption opens the next word
          // without an idle bubble; a plain bit here is dropped.
          if (accept && bus.frame_start) begin
            shift_next = load_word;
            count_next = CW'(1);
            state_next = SHIFT;
          end else begin
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Setting wins over clearing in the same cycle.
    err_next = err_set | (err_reg & ~bus.clear_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      shift_reg     <= '0;
      vec_reg       <= '0;
      vec_valid_reg <= 1'b0;
      count         <= '0;
      err_reg       <= 1'b0;
    end else begin
      state         <= state_next;
      shift_reg     <= shift_next;
      vec_reg       <= vec_next;
      vec_valid_reg <= vec_valid_next;
      count         <= count_next;
      err_reg       <= err_next;
    end
  end

  assign bus.bit_ready = ready;
  assign bus.vec       = vec_reg;
  assign bus.vec_valid = vec_valid_reg;
  assign bus.bit_count = count;
  assign bus.frame_err = err_reg;

endmodule
`default_nettype wire

// File: doc/vector_deserializer.md
Name: vector_deserializer

Overview:
- Serial-to-parallel stage that sits directly upstream of the 3-bit vector splitter.
- Collects framed serial bits into a WIDTH-bit word and presents it on vec with a valid/ready handshake.
- The splitter consumes vec; downstream logic asserts vec_ready once the word is taken.
- Detects aborted frames and flags them with a sticky error bit.

Parameters:
- WIDTH, 3: word width in bits; legal range is WIDTH >= 2.
- MSB_FIRST, 1: 1 means the first serial bit lands in vec[WIDTH-1]; 0 means it lands in vec[0].

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  bit_in is valid this cycle.
- frame_start  in  1  qualifies the current bit as the first bit of a word; meaningful only when bit_valid=1.
- bit_ready  out  1  stage can accept a bit this cycle; combinational.
- vec  out  WIDTH  assembled word, registered.
- vec_valid  out  1  vec holds a complete word, registered.
- vec_ready  in  1  consumer takes vec this cycle.
- bit_count  out  $clog2(WIDTH+1)  number of bits collected for the current word.
- frame_err  out  1  sticky error flag: frame aborted.
- clear_err  in  1  clears frame_err.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, shift register=0, vec=0, vec_valid=0, bit_count=0, frame_err=0.
  - bit_ready=1 once in IDLE.
  - Reset asserted mid-word or while FULL discards all data immediately.
- Accept condition: accept = bit_valid & bit_ready.
- bit_ready is 1 in IDLE and SHIFT. In FULL it equals vec_ready.
- States:
  - IDLE:
    - accept with frame_start=1 loads the bit, sets bit_count=1, goes to SHIFT.
    - accept with frame_start=0 discards the bit, no error, stays IDLE.
  - SHIFT:
    - accept with frame_start=0 shifts the bit in and increments bit_count.
    - When the accepted bit is the WIDTH-th bit: copy the completed word to vec, set vec_valid=1, bit_count=0, go to FULL.
    - accept with frame_start=1 (partial word abandoned): set frame_err=1, discard the partial word, load the new bit as bit 1, bit_count=1, stay in SHIFT.
  - FULL:
    - vec and vec_valid stay stable until vec_ready=1.
    - On vec_ready=1, vec_valid drops the next cycle.
    - vec_ready=1 with accept and frame_start=1: go to SHIFT with bit_count=1 (back-to-back, no bubble).
    - vec_ready=1 with accept and frame_start=0: bit discarded, go to IDLE.
    - vec_ready=1 with no accept: go to IDLE.
    - vec_ready=0: no bit accepted.
- Shift order:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], bit_in}.
  - MSB_FIRST=0: sr <= {bit_in, sr[WIDTH-1:1]}.
  - The shift register is separate from vec, so vec does not change while the next word assembles.
- Latency: vec_valid rises on the clock edge that accepts the last bit, so it is visible in the cycle after that bit.
- vec is never 'X'; it holds the last completed word (0 after reset) even while vec_valid=0.
- frame_err:
  - Set only by an aborted frame.
  - Cleared by clear_err=1.
  - A set event in the same cycle as clear_err wins, so frame_err stays 1.
- bit_valid=0 causes no state change except consumption in FULL.

Test Plan:
- Reset, then bits 1(fs=1),0,1 on consecutive cycles -> vec=3'b101, vec_valid=1 the cycle after the third bit, bit_count sequence 1,2,0.
- Word complete with vec_ready=0 for 5 cycles, bit_valid held at 1 -> bit_ready=0, vec=3'b101 stable; vec_ready=1 -> vec_valid=0 the next cycle.
- Bits 1(fs=1),1, then 0(fs=1),0,1 -> frame_err=1, vec=3'b001; then clear_err=1 -> frame_err=0.
- Back-to-back words 110 and 011 with vec_ready=1, and fs on the first bit of the second word coinciding with consumption -> vec_valid pulses twice, vec=3'b110 then 3'b011, no idle cycle.
- MSB_FIRST=0, bits 1(fs=1),0,0 -> vec=3'b001.
- rst_n low after 2 bits of a word -> immediate bit_count=0, vec_valid=0, frame_err=0; stray bits with fs=0 in IDLE -> ignored, no error.
